rotate_sample_sequencer: RTL and testbench

//  Sequences the rotated-window sampling datapath for one keypoint at a time.
//  - Takes an orientation request in 10-degree steps, 0..35.
//  - Selects one of the 9 sub-angle sample-object banks and serialises the ARR_L objects through the shared bilinear interpolator.
//  - Collects the results, applies the 90-degree quadrant permutation and presents the rotated window with a valid/ready handshake.
//  - Sits between the keypoint/orientation stage and the descriptor stage.

---
 rtl/sift_rot_pkg.sv | 22 ++
 rtl/rot_quadrant_remap.sv | 31 +++
 rtl/rotate_sample_sequencer.sv | 129 ++++++++++++
 tb/tb_rotate_sample_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sift_rot_pkg.sv
// Shared constants and types for the rotated-window sampling sequencer.
package sift_rot_pkg;

    localparam int ROT_STEPS = 36;
    localparam int SUBANG_N  = 9;

    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quad_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } rot_state_t;

endpackage

// File: rtl/rot_quadrant_remap.sv
// Maps sample object index k to its output element index p for a 90-degree quadrant.
module rot_quadrant_remap
    import sift_rot_pkg::*;
#(
    parameter int WIN_W = 4,
    parameter int IDX_W = $clog2(WIN_W * WIN_W)
) (
    input  logic [IDX_W-1:0] i_k,
    input  quad_t            i_q,
    output logic [IDX_W-1:0] o_p
);

    localparam int unsigned W = WIN_W;

    always_comb begin
        int unsigned w_gx, w_gy, w_px, w_py;
        w_gx = 32'(i_k) % W;
        w_gy = 32'(i_k) / W;
        w_px = w_gx;
        w_py = w_gy;
        case (i_q)
            QUAD_0:   begin w_px = w_gx;         w_py = w_gy;         end
            QUAD_90:  begin w_px = w_gy;         w_py = W - 1 - w_gx; end
            QUAD_180: begin w_px = W - 1 - w_gx; w_py = W - 1 - w_gy; end
            QUAD_270: begin w_px = W - 1 - w_gy; w_py = w_gx;         end
            default:  begin w_px = w_gx;         w_py = w_gy;         end
        endcase
        o_p = IDX_W'(w_py * W + w_px);
    end

endmodule

// File: rtl/rotate_sample_sequencer.sv
// Serialises one keypoint's rotated sample window through the shared interpolator
// and presents the quadrant-permuted result behind a valid/ready handshake.
module rotate_sample_sequencer
    import sift_rot_pkg::*;
#(
    parameter int WIN_W      = 4,
    parameter int ARR_L      = WIN_W * WIN_W,
    parameter int OUT_W      = 8,
    parameter int INTERP_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [5:0]               req_rot,
    output logic                     win_latch,
    output logic [3:0]               angle_sel,
    output logic [$clog2(ARR_L)-1:0] obj_idx,
    output logic                     interp_en,
    input  logic [OUT_W-1:0]         interp_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ARR_L*OUT_W-1:0]   out_win,
    output logic                     busy
);

    localparam int IDX_W = $clog2(ARR_L);
    localparam int CNT_W = $clog2(INTERP_LAT + 1);

    rot_state_t               r_state;
    quad_t                    r_quad;
    logic [3:0]               r_angle_sel;
    logic [IDX_W-1:0]         r_obj_idx;
    logic                     r_interp_en;
    logic                     r_win_latch;
    logic [CNT_W-1:0]         r_drain_cnt;
    logic [INTERP_LAT-1:0]    r_dly_v;
    logic [IDX_W-1:0]         r_dly_k [INTERP_LAT];
    logic [ARR_L*OUT_W-1:0]   r_out_win;

    logic [5:0]               w_rot_fold;
    quad_t                    w_quad;
    logic [3:0]               w_sub;
    logic [IDX_W-1:0]         w_p;

    // Out-of-range orientations (36..63) wrap exactly once.
    assign w_rot_fold = (req_rot < 6'(ROT_STEPS)) ? req_rot : req_rot - 6'(ROT_STEPS);
    assign w_quad     = quad_t'(2'(w_rot_fold / 6'(SUBANG_N)));
    assign w_sub      = 4'(w_rot_fold % 6'(SUBANG_N));

    rot_quadrant_remap #(
        .WIN_W (WIN_W),
        .IDX_W (IDX_W)
    ) u_remap (
        .i_k (r_dly_k[INTERP_LAT-1]),
        .i_q (r_quad),
        .o_p (w_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_quad      <= QUAD_0;
            r_angle_sel <= '0;
            r_obj_idx   <= '0;
            r_interp_en <= 1'b0;
            r_win_latch <= 1'b0;
            r_drain_cnt <= '0;
            r_dly_v     <= '0;
            for (int unsigned i = 0; i < INTERP_LAT; i++) r_dly_k[i] <= '0;
            r_out_win   <= '0;
        end else if (en) begin
            r_win_latch <= 1'b0;
            r_dly_v[0]  <= r_interp_en;
            r_dly_k[0]  <= r_obj_idx;
            for (int unsigned i = 1; i < INTERP_LAT; i++) begin
                r_dly_v[i] <= r_dly_v[i-1];
                r_dly_k[i] <= r_dly_k[i-1];
            end
            if (r_dly_v[INTERP_LAT-1])
                r_out_win[32'(w_p)*OUT_W +: OUT_W] <= interp_in;

            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_quad      <= w_quad;
                        r_angle_sel <= w_sub;
                        r_win_latch <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_obj_idx   <= '0;
                    r_interp_en <= 1'b1;
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (r_obj_idx == IDX_W'(ARR_L - 1)) begin
                        r_interp_en <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_obj_idx <= r_obj_idx + IDX_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == CNT_W'(INTERP_LAT - 1)) r_state <= S_OUT;
                    else r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                end
                S_OUT: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are registered but masked by en so a frozen cycle issues nothing.
    assign win_latch = r_win_latch & en;
    assign interp_en = r_interp_en & en;
    assign angle_sel = r_angle_sel;
    assign obj_idx   = r_obj_idx;
    assign out_win   = r_out_win;
    assign req_ready = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rotate_sample_sequencer.sv
// Scoreboarded random/directed bench for rotate_sample_sequencer with an interpolator stub.
module tb_rotate_sample_sequencer;

    logic         clk = 1'b0;
    logic         rst, en, req_valid, out_ready;
    logic [5:0]   req_rot;
    logic         req_ready, win_latch, interp_en, out_valid, busy;
    logic [3:0]   angle_sel, obj_idx;
    logic [7:0]   interp_in = '0;
    logic [127:0] out_win;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    rotate_sample_sequencer #(
        .WIN_W      (4),
        .OUT_W      (8),
        .INTERP_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rot   (req_rot),
        .win_latch (win_latch),
        .angle_sel (angle_sel),
        .obj_idx   (obj_idx),
        .interp_en (interp_en),
        .interp_in (interp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .busy      (busy)
    );

    // Interpolator stub: one-cycle latency, returns 3*index.
    always @(posedge clk) if (interp_en === 1'b1) interp_in <= 8'((32'(obj_idx) * 3) & 255);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: object k lands at grid (k%4, k/4) turned a quarter-turn q times.
    function automatic logic [127:0] model_win(input int rot);
        int r, q, x, y, t;
        logic [127:0] w;
        r = (rot < 36) ? rot : rot - 36;
        q = r / 9;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            x = k % 4;
            y = k / 4;
            for (int i = 0; i < q; i++) begin
                t = x;
                x = y;
                y = 3 - t;
            end
            w[(y*4 + x)*8 +: 8] = 8'((k * 3) & 255);
        end
        return w;
    endfunction

    function automatic int model_sub(input int rot);
        return ((rot < 36) ? rot : rot - 36) % 9;
    endfunction

    // Monitor: every accepted output window is popped against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_out: got window %0h, expected none", out_win);
            end else begin
                chk("out_win", out_win, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 128'(req_ready), 128'(1));
    endtask

    task automatic run_req(input int rot, input int stall, input bit freeze,
                           input int abort_k, input bit hold);
        logic [127:0] saved;
        wait_ready();
        req_valid = 1'b1;
        req_rot   = 6'(rot);
        out_ready = (stall == 0);
        chk("accept_ready", 128'(req_ready), 128'(1));
        if (abort_k < 0) exp_q.push_back(model_win(rot));
        @(negedge clk);
        req_valid = hold;
        chk("load_latch", 128'(win_latch), 128'(1));
        chk("load_angle", 128'(angle_sel), 128'(model_sub(rot)));
        chk("load_no_ready", 128'(req_ready), 128'(0));
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("issue_en", 128'(interp_en), 128'(1));
            chk("issue_idx", 128'(obj_idx), 128'(k));
            chk("issue_latch", 128'(win_latch), 128'(0));
            if (k == abort_k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                out_ready = 1'b1;
                chk("abort_idle", 128'(busy), 128'(0));
                chk("abort_en", 128'(interp_en), 128'(0));
                chk("abort_ready", 128'(req_ready), 128'(1));
                repeat (20) begin
                    @(negedge clk);
                    chk("abort_no_valid", 128'(out_valid), 128'(0));
                end
                return;
            end
            if (freeze && k == 5) begin
                en = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("freeze_idx", 128'(obj_idx), 128'(5));
                    chk("freeze_en", 128'(interp_en), 128'(0));
                end
                @(negedge clk);
                en = 1'b1;
            end
        end
        @(negedge clk);
        chk("drain_en", 128'(interp_en), 128'(0));
        chk("drain_valid", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(1));
        saved = out_win;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_ready", 128'(req_ready), 128'(0));
            chk("stall_win", out_win, saved);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_idle", 128'(req_ready), 128'(1));
        chk("post_valid", 128'(out_valid), 128'(0));
        if (hold) begin
            exp_q.push_back(model_win(rot));
            @(negedge clk);
            req_valid = 1'b0;
            chk("reaccept_latch", 128'(win_latch), 128'(1));
            wait_ready();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req_valid = 1'b0; out_ready = 1'b1; req_rot = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_interp", 128'(interp_en), 128'(0));
        chk("rst_win", out_win, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_angle", 128'(angle_sel), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_req(0, 0, 1'b0, -1, 1'b0);
        run_req(9, 0, 1'b0, -1, 1'b0);
        run_req(40, 1, 1'b0, -1, 1'b0);
        run_req(35, 0, 1'b0, -1, 1'b0);
        run_req(20, 5, 1'b0, -1, 1'b1);
        run_req(27, 0, 1'b0, 7, 1'b0);
        run_req(13, 0, 1'b0, -1, 1'b0);
        run_req(30, 0, 1'b1, -1, 1'b0);

        for (int i = 0; i < 40; i++)
            run_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0), -1, 1'b0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
